// File: rtl/stream_downsizer_pkt_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_downsizer_pkt_if
// Description : Valid/ready bundle for the packet-aware width downsizer.
//               The wide input side uses s_* signals and the narrow output
//               side uses m_* signals. The slave modport is the downsizer's
//               view. The master modport is the view of the surrounding
//               producer/consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_downsizer_pkt_if #(
    parameter int DW_OUT = 8,
    parameter int SCALE  = 4
);
    logic [DW_OUT*SCALE-1:0] s_data_i;
    logic [SCALE-1:0]        s_keep_i;
    logic                    s_last_i;
    logic                    s_valid_i;
    logic                    s_ready_o;
    logic [DW_OUT-1:0]       m_data_o;
    logic                    m_last_o;
    logic                    m_valid_o;
    logic                    m_ready_i;

    modport slave (
        input  s_data_i, s_keep_i, s_last_i, s_valid_i, m_ready_i,
        output s_ready_o, m_data_o, m_last_o, m_valid_o
    );

    modport master (
        output s_data_i, s_keep_i, s_last_i, s_valid_i, m_ready_i,
        input  s_ready_o, m_data_o, m_last_o, m_valid_o
    );
endinterface
`default_nettype wire

// File: rtl/stream_downsizer_pkt.sv
`default_nettype none
// ============================================================================
// Module      : stream_downsizer_pkt
// Description : Splits SCALE-lane input beats into DW_OUT-bit words. Only the
//               lanes flagged in the keep mask are emitted, and the packet
//               end flag is carried to the last emitted word. Lane order can
//               be selected. Beats with an empty keep mask are absorbed.
//               Optional macro STREAM_DOWNSIZER_SKID_EN adds a one-entry
//               input skid register and makes s_ready_o a registered signal.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_downsizer_pkt #(
    parameter int DW_OUT    = 8,
    parameter int SCALE     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    stream_downsizer_pkt_if.slave      bus
);
    localparam int IW    = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int DW_IN = DW_OUT * SCALE;

    // Priority encoder: first set lane in emission order. LSB-first scans
    // downwards so the lowest set lane is written last and wins. MSB-first
    // scans upwards so the highest set lane wins, which is the same as
    // encoding the bit-reversed mask.
    function automatic logic [IW-1:0] first_lane(input logic [SCALE-1:0] mask);
        logic [IW-1:0] sel;
        sel = '0;
        for (int k = 0; k < SCALE; k++) begin
            if (LSB_FIRST) begin
                if (mask[SCALE-1-k]) sel = IW'(SCALE-1-k);
            end else begin
                if (mask[k]) sel = IW'(k);
            end
        end
        return sel;
    endfunction

    logic [DW_IN-1:0] data_q;
    logic [SCALE-1:0] mask_q;
    logic             last_q;
    logic             full_q;
    logic [IW-1:0]    idx_q;

    logic [SCALE-1:0] w_lane_bit;
    logic [SCALE-1:0] w_rem;
    logic             w_final;
    logic             w_rd;
    logic             w_free;
    logic             w_wr;
    logic             w_ld;
    logic [DW_IN-1:0] w_ld_data;
    logic [SCALE-1:0] w_ld_keep;
    logic             w_ld_last;

    assign w_lane_bit = {{(SCALE-1){1'b0}}, 1'b1} << idx_q;
    assign w_rem      = mask_q & ~w_lane_bit;
    assign w_final    = full_q & (w_rem == '0);
    assign w_rd       = full_q & bus.m_ready_i;
    // The main register is free now, or it becomes free at this edge.
    assign w_free     = !full_q | (w_rd & w_final);
    assign w_wr       = bus.s_valid_i & bus.s_ready_o;

`ifdef STREAM_DOWNSIZER_SKID_EN
    logic [DW_IN-1:0] sk_data_q;
    logic [SCALE-1:0] sk_keep_q;
    logic             sk_last_q;
    logic             sk_full_q;
    logic             sk_full_d;
    logic             s_ready_q;
    logic             w_wr_keep;

    // Beats with no lanes never occupy storage.
    assign w_wr_keep = w_wr & (|bus.s_keep_i);

    // Choose the main-register load source. A held skid beat has priority.
    // A skid beat exists only while s_ready_o is low, so it never competes
    // with a new input beat.
    always_comb begin
        w_ld      = 1'b0;
        w_ld_data = bus.s_data_i;
        w_ld_keep = bus.s_keep_i;
        w_ld_last = bus.s_last_i;
        sk_full_d = sk_full_q;
        if (w_free) begin
            if (sk_full_q) begin
                w_ld      = 1'b1;
                w_ld_data = sk_data_q;
                w_ld_keep = sk_keep_q;
                w_ld_last = sk_last_q;
                sk_full_d = 1'b0;
            end else if (w_wr_keep) begin
                w_ld = 1'b1;
            end
        end else if (w_wr_keep) begin
            sk_full_d = 1'b1;
        end
    end

    // Skid register and registered ready. Ready is the inverse of the next
    // skid occupancy, so m_ready_i has no combinational path to s_ready_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            sk_data_q <= '0;
            sk_keep_q <= '0;
            sk_last_q <= 1'b0;
            sk_full_q <= 1'b0;
            s_ready_q <= 1'b0;
        end else begin
            sk_full_q <= sk_full_d;
            s_ready_q <= !sk_full_d;
            if (!w_free && w_wr_keep) begin
                sk_data_q <= bus.s_data_i;
                sk_keep_q <= bus.s_keep_i;
                sk_last_q <= bus.s_last_i;
            end
        end
    end

    assign bus.s_ready_o = s_ready_q & !rst;
`else
    logic rst_r_q;

    // Delay reset by one cycle to hold off the producer for a cycle after
    // reset is released.
    always_ff @(posedge clk) begin
        rst_r_q <= rst;
    end

    assign w_ld      = w_wr & (|bus.s_keep_i);
    assign w_ld_data = bus.s_data_i;
    assign w_ld_keep = bus.s_keep_i;
    assign w_ld_last = bus.s_last_i;

    assign bus.s_ready_o = w_free & !rst_r_q & !rst;
`endif

    // Main beat register. Load a new beat, or retire the lane just read and
    // move to the next remaining lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            mask_q <= '0;
            last_q <= 1'b0;
            full_q <= 1'b0;
            idx_q  <= '0;
        end else if (w_ld) begin
            data_q <= w_ld_data;
            mask_q <= w_ld_keep;
            last_q <= w_ld_last;
            full_q <= 1'b1;
            idx_q  <= first_lane(w_ld_keep);
        end else if (w_rd) begin
            mask_q <= w_rem;
            idx_q  <= first_lane(w_rem);
            if (w_final) full_q <= 1'b0;
        end
    end

    assign bus.m_data_o  = data_q[idx_q*DW_OUT +: DW_OUT];
    assign bus.m_valid_o = full_q;
    assign bus.m_last_o  = full_q & last_q & w_final;
endmodule
`default_nettype wire

// File: tb/tb_stream_downsizer_pkt.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_downsizer_pkt
// Description : Scoreboard bench for stream_downsizer_pkt. An LSB-first and
//               an MSB-first instance receive the same input stream. Each
//               instance has its own expected-word queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_downsizer_pkt;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_ready_tb = 1'b1;
    logic stall_en = 1'b0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic       pstall[2];
    logic [7:0] pd[2];
    logic       pl[2];

    stream_downsizer_pkt_if #(.DW_OUT(8), .SCALE(4)) bus0 ();
    stream_downsizer_pkt_if #(.DW_OUT(8), .SCALE(4)) bus1 ();

    stream_downsizer_pkt #(.DW_OUT(8), .SCALE(4), .LSB_FIRST(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0));
    stream_downsizer_pkt #(.DW_OUT(8), .SCALE(4), .LSB_FIRST(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1));

    assign bus1.s_data_i  = bus0.s_data_i;
    assign bus1.s_keep_i  = bus0.s_keep_i;
    assign bus1.s_last_i  = bus0.s_last_i;
    assign bus1.s_valid_i = bus0.s_valid_i;
    assign bus0.m_ready_i = m_ready_tb;
    assign bus1.m_ready_i = m_ready_tb;

    always #5 clk = ~clk;

    // Cycle index, used to locate words at exact cycles.
    always @(posedge clk) cyc <= cyc + 1;

    // Consumer ready: 50% random while stalls are enabled, otherwise high.
    always @(posedge clk) begin
        #1;
        m_ready_tb = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected words for one beat on both instances: {last, data}.
    task automatic push_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        int c;
        n = $countones(k);
        c = 0;
        for (int j = 0; j < 4; j++) begin
            if (k[j]) begin
                c++;
                q0.push_back({l && (c == n), d[j*8 +: 8]});
            end
        end
        c = 0;
        for (int j = 3; j >= 0; j--) begin
            if (k[j]) begin
                c++;
                q1.push_back({l && (c == n), d[j*8 +: 8]});
            end
        end
    endtask

    // Checks one observed output of channel ch against the queue. It also
    // checks that a stalled word stays unchanged.
    task automatic mon(input int ch, input logic v, input logic rdy,
                       input logic [7:0] d, input logic l);
        logic [8:0] e;
        if (pstall[ch]) begin
            chk($sformatf("stall_hold%0d", ch), {23'd0, v, l, d}, {23'd0, 1'b1, pl[ch], pd[ch]});
        end
        if (v && rdy) begin
            if ((ch == 0 && q0.size() == 0) || (ch == 1 && q1.size() == 0)) begin
                chk($sformatf("unexpected_word%0d", ch), {23'd0, l, d}, 32'hFFFF_FFFF);
            end else begin
                e = (ch == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("word%0d", ch), {23'd0, l, d}, {23'd0, e});
            end
        end
        pstall[ch] = v && !rdy;
        pd[ch] = d;
        pl[ch] = l;
    endtask

    // Scoreboard monitor. It samples at the falling edge, between transfers.
    always @(negedge clk) begin
        if (rst) begin
            pstall[0] = 1'b0;
            pstall[1] = 1'b0;
        end else begin
            mon(0, bus0.m_valid_o, bus0.m_ready_i, bus0.m_data_o, bus0.m_last_o);
            mon(1, bus1.m_valid_o, bus1.m_ready_i, bus1.m_data_o, bus1.m_last_o);
        end
    end

    // Offers a beat until it is accepted. Called and returns just after a
    // rising edge.
    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
        logic ok;
        logic done;
        done = 1'b0;
        bus0.s_data_i  = d;
        bus0.s_keep_i  = k;
        bus0.s_last_i  = l;
        bus0.s_valid_i = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            ok = bus0.s_ready_o;
            @(posedge clk);
            #1;
            if (ok) begin
                done = 1'b1;
                acc_cyc = cyc;
                push_beat(d, k, l);
            end
        end
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        bus0.s_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 500 && (q0.size() != 0 || q1.size() != 0); t++) @(posedge clk);
        #1;
        chk("drain", q0.size() + q1.size(), 32'd0);
    endtask

    // Checks the LSB-first instance's output word in a given cycle.
    task automatic expect_at(input int target, input logic [7:0] d, input logic l,
                             input logic chk_rdy, input string name);
        for (int t = 0; t < 100 && cyc < target; t++) @(negedge clk);
        if (cyc < target || $time % 10 != 0) @(negedge clk);
        chk({name, "_cyc"}, cyc, target);
        chk(name, {23'd0, bus0.m_valid_o, bus0.m_last_o, bus0.m_data_o}, {23'd0, 1'b1, l, d});
        if (chk_rdy) chk({name, "_rdy"}, {31'd0, bus0.s_ready_o}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a1;
        bus0.s_data_i  = '0;
        bus0.s_keep_i  = '0;
        bus0.s_last_i  = 1'b0;
        bus0.s_valid_i = 1'b0;
        pstall[0] = 1'b0;
        pstall[1] = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state0", {29'd0, bus0.s_ready_o, bus0.m_valid_o, bus0.m_last_o}, 32'd0);
        chk("rst_state1", {29'd0, bus1.s_ready_o, bus1.m_valid_o, bus1.m_last_o}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rdy_after_rst", {31'd0, bus0.s_ready_o}, 32'd0);
        @(negedge clk);
        chk("rdy_up", {31'd0, bus0.s_ready_o}, 32'd1);
        @(posedge clk);
        #1;

        // Full beat, unstalled. The final word appears 3 cycles after the
        // first, and ready is high in that cycle.
        send(32'h44332211, 4'hF, 1'b1);
        idle();
        expect_at(acc_cyc + 3, 8'h44, 1'b1, 1'b1, "t1_last");
        drain();

        // Sparse keep mask.
        send(32'h44332211, 4'b1010, 1'b1);
        idle();
        drain();

        // Back-to-back beats: eight words with no gap.
        send(32'h44332211, 4'hF, 1'b0);
        a1 = acc_cyc;
        send(32'h88776655, 4'hF, 1'b1);
        idle();
        expect_at(a1 + 7, 8'h88, 1'b1, 1'b0, "t3_gapless");
        drain();

        // Same traffic with random consumer stalls.
        stall_en = 1'b1;
        send(32'h44332211, 4'hF, 1'b0);
        send(32'h88776655, 4'hF, 1'b1);
        send(32'hAABBCCDD, 4'b0110, 1'b1);
        idle();
        drain();
        stall_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Empty beat is absorbed, then a single-lane beat.
        send(32'hDEADBEEF, 4'b0000, 1'b1);
        send(32'hAABBCCDD, 4'b0001, 1'b1);
        idle();
        drain();

        // Reset after the second word of a four-word beat.
        send(32'h44332211, 4'hF, 1'b1);
        idle();
        @(posedge clk);
        #1;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        @(negedge clk);
        chk("rdy_in_rst", {31'd0, bus0.s_ready_o}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst0", {29'd0, bus0.s_ready_o, bus0.m_valid_o, bus0.m_last_o}, 32'd0);
        chk("post_rst1", {29'd0, bus1.s_ready_o, bus1.m_valid_o, bus1.m_last_o}, 32'd0);
        @(negedge clk);
        chk("rdy_post_rst", {31'd0, bus0.s_ready_o}, 32'd1);
        @(posedge clk);
        #1;
        send(32'h99887766, 4'hF, 1'b1);
        idle();
        expect_at(acc_cyc, 8'h66, 1'b0, 1'b0, "t6_first");
        drain();

        chk("queues_empty", q0.size() + q1.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/stream_downsizer_pkt.md
# stream_downsizer_pkt

Packet-aware width downsizer for valid/ready streams. Splits each accepted input beat of SCALE lanes × DW_OUT bits into DW_OUT-bit output words, emitting only the lanes marked in a per-lane keep mask. It carries an end-of-packet flag through to the last emitted word and has selectable lane order. It sits between wide datapath producers (DMA, bus bridges) and narrow consumers (serialisers, UART/SPI framers).

## Interface
Parameters:
- DW_OUT, 8, output word width in bits (≥1)
- SCALE, 4, lanes per input beat (≥2)
- LSB_FIRST, 1, 1: lane 0 (bits [DW_OUT-1:0]) emitted first; 0: lane SCALE-1 first

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- s_data_i  in  DW_OUT*SCALE  input beat; lane k = bits [k*DW_OUT +: DW_OUT]
- s_keep_i  in  SCALE  lane k present when bit k = 1
- s_last_i  in  1  beat ends a packet
- s_valid_i  in  1  input beat valid
- s_ready_o  out  1  block can accept a beat
- m_data_o  out  DW_OUT  current output word
- m_last_o  out  1  current word is the final word of a packet
- m_valid_o  out  1  output word valid
- m_ready_i  in  1  consumer accepts word

## Operation
- Transfer on a side when valid & ready are both high in the same cycle. wr = s_valid_i & s_ready_o; rd = m_valid_o & m_ready_i.
- State: beat register (data, keep-remaining mask, last flag), full flag, current lane index idx (width $clog2(SCALE), min 1).
- On wr, the beat is captured with keep mask = s_keep_i. idx is set to the first set bit in emission order.
- On rd, the emitted lane's bit is cleared from the remaining mask. idx advances to the next set bit in emission order, skipping cleared lanes with no bubble cycles.
- The final word is the one whose lane is the only remaining set bit. On rd of that word, full clears unless wr occurs in the same cycle.
- m_data_o = beat lane idx. m_valid_o = full.
- m_last_o = full & stored last & (current lane is the final remaining lane).
- s_ready_o = (!full | (rd on final word)) & !rst_r, where rst_r is rst delayed one cycle.
- A beat with s_keep_i = 0 is accepted and discarded: no output words, and its s_last_i is dropped. full is not set by it. Back-to-back all-zero beats are absorbed at 1 beat/cycle.
- Single-lane beat (one keep bit set): one output word. m_last_o follows s_last_i.
- Arithmetic: next-lane search is a priority encode over the remaining mask in emission order. The mask is bit-reversed when LSB_FIRST = 0.

## Timing
- Latency: a beat accepted at edge N presents its first word with m_valid_o = 1 after edge N (visible in cycle N+1).
- Throughput: one word per cycle while m_ready_i = 1. A new beat is accepted in the same cycle its predecessor's final word is read, giving zero bubbles between beats.
- Outputs are stable while m_valid_o & !m_ready_i. m_data_o is don't-care when m_valid_o = 0.
- Reset: while rst = 1 and for one cycle after, s_ready_o = 0. After the reset edge, m_valid_o = 0, m_last_o = 0, idx = 0, mask = 0, and the data register = 0.
- Reset mid-beat discards all remaining words. No partial packet state survives.
- s_ready_o depends combinationally on m_ready_i (see Configuration).

## Configuration
- STREAM_DOWNSIZER_SKID_EN defined:
  - Adds a one-entry input skid register, and s_ready_o becomes a registered signal equal to !skid_full & !rst_r. There is no combinational path from m_ready_i to s_ready_o.
  - A beat is captured into the skid register only when the main register is occupied and not being freed that cycle. Otherwise it bypasses directly into the main register.
  - First-word latency and zero-bubble throughput are unchanged. Up to two beats can be held.
- Not defined: no skid register, with the combinational s_ready_o described above.

## Test plan
- DW_OUT=8, SCALE=4, LSB_FIRST=1, m_ready_i=1: beat 0x44332211, keep 4'hF, last=1 -> words 0x11,0x22,0x33,0x44 on four consecutive cycles; m_last_o=1 only on 0x44; s_ready_o high in the 0x44 cycle.
- Same beat with keep 4'b1010, last=1 -> words 0x22, 0x44; m_last_o on 0x44. Repeat with LSB_FIRST=0 and keep 4'hF -> 0x44,0x33,0x22,0x11, m_last_o on 0x11.
- Two back-to-back beats 0x44332211 / 0x88776655, keep 4'hF, last=0/1, s_valid held -> eight words with no gap; m_last_o only on 0x88.
- Random m_ready_i stalls at 50% -> output sequence identical to the unstalled run; m_data_o and m_last_o stable across every stall cycle.
- Beat with keep 0, last=1, followed by 0xAABBCCDD with keep 4'b0001, last=1 -> first beat accepted with no output; single word 0xDD with m_last_o=1.
- Assert rst after the 2nd word of a 4-word beat -> m_valid_o=0 after the reset edge; s_ready_o=0 for the reset cycle plus one; the next beat emits from its first lane.
